// File: rtl/rename_ckpt_stage_if.sv
// Decode, issue, resolve and commit signals of the rename stage.
// The master side drives the decoder/commit inputs; the stage is the slave.
interface rename_ckpt_stage_if #(
   parameter int AW = 3,
   parameter int PW = 5,
   parameter int CW = 2
);
   logic          dec_v_i;
   logic          dec_ready_o;
   logic [AW-1:0] dec_src1_i;
   logic [AW-1:0] dec_src2_i;
   logic [AW-1:0] dec_dest_i;
   logic          dec_w_v_i;
   logic          dec_branch_i;
   logic          ren_v_o;
   logic          ren_ready_i;
   logic [PW-1:0] ren_src1_o;
   logic [PW-1:0] ren_src2_o;
   logic [PW-1:0] ren_dest_o;
   logic [PW-1:0] ren_freed_o;
   logic [CW-1:0] ren_ckpt_id_o;
   logic          resolve_v_i;
   logic [CW-1:0] resolve_id_i;
   logic          resolve_mispredict_i;
   logic          commit_v_i;
   logic          commit_w_v_i;
   logic [AW-1:0] commit_dest_i;
   logic [PW-1:0] commit_freed_i;
   logic          flush_i;

   modport master (
      output dec_v_i, dec_src1_i, dec_src2_i, dec_dest_i,
      output dec_w_v_i, dec_branch_i, ren_ready_i,
      output resolve_v_i, resolve_id_i, resolve_mispredict_i,
      output commit_v_i, commit_w_v_i, commit_dest_i,
      output commit_freed_i, flush_i,
      input  dec_ready_o, ren_v_o, ren_src1_o, ren_src2_o,
      input  ren_dest_o, ren_freed_o, ren_ckpt_id_o
   );

   modport slave (
      input  dec_v_i, dec_src1_i, dec_src2_i, dec_dest_i,
      input  dec_w_v_i, dec_branch_i, ren_ready_i,
      input  resolve_v_i, resolve_id_i, resolve_mispredict_i,
      input  commit_v_i, commit_w_v_i, commit_dest_i,
      input  commit_freed_i, flush_i,
      output dec_ready_o, ren_v_o, ren_src1_o, ren_src2_o,
      output ren_dest_o, ren_freed_o, ren_ckpt_id_o
   );
endinterface

// File: rtl/rename_ckpt_stage.sv
// Register rename with speculative LUT, circular freelist and
// per-branch checkpoints for single-cycle mispredict recovery.
module rename_ckpt_stage #(
   parameter int NUM_ARCH_REG = 8,
   parameter int NUM_PHYS_REG = 32,
   parameter int NUM_CKPT     = 4
) (
   input  logic clk_i,
   input  logic reset_n_i,
   rename_ckpt_stage_if.slave io
);
   localparam int AW    = $clog2(NUM_ARCH_REG);
   localparam int PW    = $clog2(NUM_PHYS_REG);
   localparam int CW    = $clog2(NUM_CKPT);
   localparam int NFREE = NUM_PHYS_REG - NUM_ARCH_REG;

   localparam logic [PW:0] FL_ONE = {{PW{1'b0}}, 1'b1};
   localparam logic [CW:0] CK_ONE = {{CW{1'b0}}, 1'b1};
   localparam logic [CW:0] CK_FULL = {1'b1, {CW{1'b0}}};

   typedef logic [NUM_ARCH_REG-1:0][PW-1:0] lut_t;

   lut_t spec_lut_q, spec_lut_d;
   lut_t commit_lut_q, commit_lut_d;
   logic [NUM_PHYS_REG-1:0][PW-1:0] fl_q, fl_d;
   logic [PW:0] fl_rd_q, fl_rd_d;
   logic [PW:0] fl_wr_q, fl_wr_d;
   logic [PW:0] commit_rd_q, commit_rd_d;
   logic [NUM_CKPT-1:0][NUM_ARCH_REG-1:0][PW-1:0] ckpt_lut_q, ckpt_lut_d;
   logic [NUM_CKPT-1:0][PW:0] ckpt_fl_rd_q, ckpt_fl_rd_d;
   logic [CW:0] head_q, head_d;
   logic [CW:0] tail_q, tail_d;

   logic          ren_v_q, ren_v_d;
   logic [PW-1:0] ren_src1_q, ren_src1_d;
   logic [PW-1:0] ren_src2_q, ren_src2_d;
   logic [PW-1:0] ren_dest_q, ren_dest_d;
   logic [PW-1:0] ren_freed_q, ren_freed_d;
   logic [CW-1:0] ren_ckpt_id_q, ren_ckpt_id_d;

   logic [PW:0]   fl_count;
   logic          ring_full;
   logic          mispredict;
   logic          out_free;
   logic          dec_ready;
   logic          accept;
   logic [PW-1:0] alloc_preg;
   lut_t          upd_lut;
   logic [PW:0]   upd_rd;
   logic [CW-1:0] rewind_dist;

   assign fl_count   = fl_wr_q - fl_rd_q;
   assign ring_full  = (tail_q ^ head_q) == CK_FULL;
   assign mispredict = io.resolve_v_i && io.resolve_mispredict_i;
   assign out_free   = !ren_v_q || io.ren_ready_i;
   assign alloc_preg = fl_q[fl_rd_q[PW-1:0]];

   assign dec_ready = out_free && !io.flush_i && !mispredict
                   && !(io.dec_w_v_i && fl_count == '0)
                   && !(io.dec_branch_i && ring_full);
   assign accept    = io.dec_v_i && dec_ready;

   assign io.dec_ready_o   = dec_ready;
   assign io.ren_v_o       = ren_v_q;
   assign io.ren_src1_o    = ren_src1_q;
   assign io.ren_src2_o    = ren_src2_q;
   assign io.ren_dest_o    = ren_dest_q;
   assign io.ren_freed_o   = ren_freed_q;
   assign io.ren_ckpt_id_o = ren_ckpt_id_q;

   // LUT and read pointer as they stand after this instruction renames
   always_comb begin
      upd_lut = spec_lut_q;
      upd_rd  = fl_rd_q;
      if (io.dec_w_v_i) begin
         upd_lut[io.dec_dest_i] = alloc_preg;
         upd_rd = fl_rd_q + FL_ONE;
      end
   end

   assign rewind_dist = io.resolve_id_i - head_q[CW-1:0];

   always_comb begin
      spec_lut_d    = spec_lut_q;
      commit_lut_d  = commit_lut_q;
      fl_d          = fl_q;
      fl_rd_d       = fl_rd_q;
      fl_wr_d       = fl_wr_q;
      commit_rd_d   = commit_rd_q;
      ckpt_lut_d    = ckpt_lut_q;
      ckpt_fl_rd_d  = ckpt_fl_rd_q;
      head_d        = head_q;
      tail_d        = tail_q;
      ren_v_d       = ren_v_q;
      ren_src1_d    = ren_src1_q;
      ren_src2_d    = ren_src2_q;
      ren_dest_d    = ren_dest_q;
      ren_freed_d   = ren_freed_q;
      ren_ckpt_id_d = ren_ckpt_id_q;

      if (io.commit_v_i && io.commit_w_v_i) begin
         fl_d[fl_wr_q[PW-1:0]] = io.commit_freed_i;
         fl_wr_d = fl_wr_q + FL_ONE;
         commit_lut_d[io.commit_dest_i] = fl_q[commit_rd_q[PW-1:0]];
         commit_rd_d = commit_rd_q + FL_ONE;
      end

      unique case (1'b1)
         io.flush_i: begin
            spec_lut_d = commit_lut_d;
            fl_rd_d    = commit_rd_d;
            tail_d     = head_q;
            ren_v_d    = 1'b0;
         end
         mispredict && !io.flush_i: begin
            spec_lut_d = ckpt_lut_q[io.resolve_id_i];
            fl_rd_d    = ckpt_fl_rd_q[io.resolve_id_i];
            tail_d     = head_q + {1'b0, rewind_dist};
            ren_v_d    = 1'b0;
         end
         default: begin
            if (io.resolve_v_i) head_d = head_q + CK_ONE;
            if (out_free) begin
               ren_v_d = accept;
               if (accept) begin
                  ren_src1_d    = spec_lut_q[io.dec_src1_i];
                  ren_src2_d    = spec_lut_q[io.dec_src2_i];
                  ren_dest_d    = io.dec_w_v_i ? alloc_preg : '0;
                  ren_freed_d   = io.dec_w_v_i ?
                                  spec_lut_q[io.dec_dest_i] : '0;
                  ren_ckpt_id_d = io.dec_branch_i ? tail_q[CW-1:0] : '0;
                  spec_lut_d    = upd_lut;
                  fl_rd_d       = upd_rd;
                  if (io.dec_branch_i) begin
                     ckpt_lut_d[tail_q[CW-1:0]]   = upd_lut;
                     ckpt_fl_rd_d[tail_q[CW-1:0]] = upd_rd;
                     tail_d = tail_q + CK_ONE;
                  end
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         for (int i = 0; i < NUM_ARCH_REG; i++) begin
            spec_lut_q[i]   <= PW'(i);
            commit_lut_q[i] <= PW'(i);
         end
         for (int i = 0; i < NUM_PHYS_REG; i++) begin
            fl_q[i] <= PW'(i + NUM_ARCH_REG);
         end
         fl_rd_q       <= '0;
         fl_wr_q       <= (PW+1)'(NFREE);
         commit_rd_q   <= '0;
         ckpt_lut_q    <= '0;
         ckpt_fl_rd_q  <= '0;
         head_q        <= '0;
         tail_q        <= '0;
         ren_v_q       <= 1'b0;
         ren_src1_q    <= '0;
         ren_src2_q    <= '0;
         ren_dest_q    <= '0;
         ren_freed_q   <= '0;
         ren_ckpt_id_q <= '0;
      end else begin
         spec_lut_q    <= spec_lut_d;
         commit_lut_q  <= commit_lut_d;
         fl_q          <= fl_d;
         fl_rd_q       <= fl_rd_d;
         fl_wr_q       <= fl_wr_d;
         commit_rd_q   <= commit_rd_d;
         ckpt_lut_q    <= ckpt_lut_d;
         ckpt_fl_rd_q  <= ckpt_fl_rd_d;
         head_q        <= head_d;
         tail_q        <= tail_d;
         ren_v_q       <= ren_v_d;
         ren_src1_q    <= ren_src1_d;
         ren_src2_q    <= ren_src2_d;
         ren_dest_q    <= ren_dest_d;
         ren_freed_q   <= ren_freed_d;
         ren_ckpt_id_q <= ren_ckpt_id_d;
      end
   end

   logic unused_aw;
   assign unused_aw = ^AW;
endmodule

// File: tb/tb_rename_ckpt_stage.sv
// Bench for rename_ckpt_stage: directed scenarios plus a random run
// checked every cycle against a queue-based rename model.
module tb_rename_ckpt_stage;
   localparam int NA = 8;
   localparam int NP = 32;
   localparam int NC = 4;
   localparam int AW = 3;
   localparam int PW = 5;
   localparam int CW = 2;

   logic clk_i = 1'b0;
   logic reset_n_i = 1'b1;
   always #5 clk_i = ~clk_i;

   rename_ckpt_stage_if #(.AW(AW), .PW(PW), .CW(CW)) bus ();

   rename_ckpt_stage #(
      .NUM_ARCH_REG(NA), .NUM_PHYS_REG(NP), .NUM_CKPT(NC)
   ) dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i), .io(bus)
   );

   int checks = 0;
   int errors = 0;

   // model: maps, free regs in allocation order, in-flight allocations
   int m_spec[NA];
   int m_commit[NA];
   int m_free[$];
   int a_phys[$];
   int a_arch[$];
   int a_old[$];
   int ck_ids[$];
   int ck_lut[NC][NA];
   int ck_len[NC];
   int m_head;
   bit e_v, e_br;
   int e_s1, e_s2, e_dest, e_freed, e_ck;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NA; i++) begin
         m_spec[i] = i;
         m_commit[i] = i;
      end
      m_free.delete();
      for (int i = NA; i < NP; i++) m_free.push_back(i);
      a_phys.delete(); a_arch.delete(); a_old.delete();
      ck_ids.delete();
      m_head = 0;
      e_v = 0; e_br = 0;
      e_s1 = 0; e_s2 = 0; e_dest = 0; e_freed = 0; e_ck = 0;
   endtask

   function automatic bit model_ready();
      return (!e_v || bus.ren_ready_i) && !bus.flush_i
          && !(bus.resolve_v_i && bus.resolve_mispredict_i)
          && !(bus.dec_w_v_i && m_free.size() == 0)
          && !(bus.dec_branch_i && ck_ids.size() == NC);
   endfunction

   task automatic undo_to(int n);
      while (a_phys.size() > n) begin
         m_free.push_front(a_phys.pop_back());
         a_arch.delete(a_arch.size() - 1);
         a_old.delete(a_old.size() - 1);
      end
   endtask

   task automatic model_step();
      bit acc;
      int k, id, ph;
      acc = bus.dec_v_i && model_ready();
      if (bus.commit_v_i && bus.commit_w_v_i) begin
         m_commit[bus.commit_dest_i] = a_phys.pop_front();
         a_arch.delete(0);
         a_old.delete(0);
         m_free.push_back(int'(bus.commit_freed_i));
      end
      if (bus.flush_i) begin
         for (int i = 0; i < NA; i++) m_spec[i] = m_commit[i];
         undo_to(0);
         ck_ids.delete();
         e_v = 0;
      end else if (bus.resolve_v_i && bus.resolve_mispredict_i) begin
         id = int'(bus.resolve_id_i);
         k = 0;
         foreach (ck_ids[j]) if (ck_ids[j] == id) k = j;
         for (int i = 0; i < NA; i++) m_spec[i] = ck_lut[id][i];
         undo_to(ck_len[id]);
         while (ck_ids.size() > k) ck_ids.delete(ck_ids.size() - 1);
         e_v = 0;
      end else begin
         if (bus.resolve_v_i) begin
            ck_ids.delete(0);
            m_head = (m_head + 1) % NC;
         end
         if (!e_v || bus.ren_ready_i) begin
            e_v = acc;
            if (acc) begin
               e_s1 = m_spec[bus.dec_src1_i];
               e_s2 = m_spec[bus.dec_src2_i];
               e_br = bus.dec_branch_i;
               e_dest = 0; e_freed = 0; e_ck = 0;
               if (bus.dec_w_v_i) begin
                  ph = m_free.pop_front();
                  e_dest = ph;
                  e_freed = m_spec[bus.dec_dest_i];
                  a_phys.push_back(ph);
                  a_arch.push_back(int'(bus.dec_dest_i));
                  a_old.push_back(e_freed);
                  m_spec[bus.dec_dest_i] = ph;
               end
               if (bus.dec_branch_i) begin
                  id = (m_head + ck_ids.size()) % NC;
                  for (int i = 0; i < NA; i++) ck_lut[id][i] = m_spec[i];
                  ck_len[id] = a_phys.size();
                  ck_ids.push_back(id);
                  e_ck = id;
               end
            end
         end
      end
   endtask

   task automatic compare_out();
      chk("ren_v", 32'(bus.ren_v_o), 32'(e_v));
      if (e_v) begin
         chk("ren_src1", 32'(bus.ren_src1_o), e_s1);
         chk("ren_src2", 32'(bus.ren_src2_o), e_s2);
         chk("ren_dest", 32'(bus.ren_dest_o), e_dest);
         chk("ren_freed", 32'(bus.ren_freed_o), e_freed);
         if (e_br) chk("ren_ckpt_id", 32'(bus.ren_ckpt_id_o), e_ck);
      end
   endtask

   // entered at a falling edge with inputs driven; leaves at the next one
   task automatic cycle();
      #1;
      chk("dec_ready", 32'(bus.dec_ready_o), 32'(model_ready()));
      model_step();
      @(posedge clk_i);
      #1;
      compare_out();
      @(negedge clk_i);
   endtask

   task automatic idle();
      bus.dec_v_i = 0; bus.dec_src1_i = '0; bus.dec_src2_i = '0;
      bus.dec_dest_i = '0; bus.dec_w_v_i = 0; bus.dec_branch_i = 0;
      bus.ren_ready_i = 1;
      bus.resolve_v_i = 0; bus.resolve_id_i = '0;
      bus.resolve_mispredict_i = 0;
      bus.commit_v_i = 0; bus.commit_w_v_i = 0;
      bus.commit_dest_i = '0; bus.commit_freed_i = '0;
      bus.flush_i = 0;
   endtask

   task automatic dec(bit v, int s1, int s2, int d, bit w, bit br);
      idle();
      bus.dec_v_i = v;
      bus.dec_src1_i = AW'(s1);
      bus.dec_src2_i = AW'(s2);
      bus.dec_dest_i = AW'(d);
      bus.dec_w_v_i = w;
      bus.dec_branch_i = br;
   endtask

   task automatic resolve(int id, bit mis);
      bus.resolve_v_i = 1;
      bus.resolve_id_i = CW'(id);
      bus.resolve_mispredict_i = mis;
   endtask

   task automatic do_reset();
      idle();
      model_reset();
      reset_n_i = 1'b0;
      repeat (2) @(negedge clk_i);
      reset_n_i = 1'b1;
   endtask

   task automatic rand_inputs();
      int fb, k;
      dec(($urandom % 4) != 0, $urandom_range(0, NA-1),
          $urandom_range(0, NA-1), $urandom_range(0, NA-1),
          ($urandom % 4) != 0, ($urandom % 5) == 0);
      bus.ren_ready_i = ($urandom % 4) != 0;
      fb = (e_v && e_br) ? e_ck : -1;
      if (ck_ids.size() > 0 && ($urandom % 5) == 0) begin
         if (($urandom % 3) == 0) begin
            k = $urandom_range(0, ck_ids.size() - 1);
            if (ck_ids[k] != fb) resolve(ck_ids[k], 1);
         end else if (ck_ids[0] != fb) begin
            resolve(ck_ids[0], 0);
         end
      end
      if (ck_ids.size() == 0 && a_phys.size() > 0 && ($urandom % 3) == 0) begin
         bus.commit_v_i = 1;
         bus.commit_w_v_i = 1;
         bus.commit_dest_i = AW'(a_arch[0]);
         bus.commit_freed_i = PW'(a_old[0]);
      end
      bus.flush_i = ($urandom % 60) == 0;
   endtask

   initial begin
      idle();
      #2;
      do_reset();
      chk("rst_v", 32'(bus.ren_v_o), 0);
      chk("rst_dest", 32'(bus.ren_dest_o), 0);
      chk("rst_freed", 32'(bus.ren_freed_o), 0);
      chk("rst_src1", 32'(bus.ren_src1_o), 0);
      chk("rst_ckpt", 32'(bus.ren_ckpt_id_o), 0);

      // three writes of r1, the last also reading r1
      for (int i = 0; i < 3; i++) begin
         dec(1, 1, 0, 1, 1, 0);
         cycle();
         chk("t1_dest", 32'(bus.ren_dest_o), 8 + i);
         chk("t1_freed", 32'(bus.ren_freed_o), (i == 0) ? 1 : 7 + i);
      end
      chk("t1_src1", 32'(bus.ren_src1_o), 9);

      // freelist exhaustion and wrap
      do_reset();
      for (int i = 0; i < 24; i++) begin
         dec(1, 0, 0, i % NA, 1, 0);
         cycle();
      end
      dec(1, 0, 0, 5, 1, 0);
      #1 chk("t2_stall", 32'(bus.dec_ready_o), 0);
      cycle();
      idle();
      bus.commit_v_i = 1; bus.commit_w_v_i = 1;
      bus.commit_dest_i = AW'(a_arch[0]); bus.commit_freed_i = PW'(3);
      cycle();
      dec(1, 0, 0, 6, 1, 0);
      cycle();
      chk("t2_wrap_dest", 32'(bus.ren_dest_o), 3);

      // mispredict rewinds to the checkpoint
      do_reset();
      dec(1, 0, 0, 1, 1, 0); cycle();
      dec(1, 0, 0, 2, 1, 0); cycle();
      dec(1, 0, 0, 0, 0, 1); cycle();
      chk("t3_ckpt", 32'(bus.ren_ckpt_id_o), 0);
      for (int d = 3; d < 6; d++) begin
         dec(1, 0, 0, d, 1, 0); cycle();
      end
      idle(); resolve(0, 1); cycle();
      chk("t3_kill", 32'(bus.ren_v_o), 0);
      dec(1, 3, 2, 6, 1, 0); cycle();
      chk("t3_dest", 32'(bus.ren_dest_o), 10);
      chk("t3_src1", 32'(bus.ren_src1_o), 3);
      chk("t3_src2", 32'(bus.ren_src2_o), 9);

      // checkpoint ring full
      do_reset();
      for (int i = 0; i < 4; i++) begin
         dec(1, 0, 0, 0, 0, 1); cycle();
         chk("t4_id", 32'(bus.ren_ckpt_id_o), i);
      end
      dec(1, 0, 0, 0, 0, 1); resolve(0, 0);
      #1 chk("t4_stall", 32'(bus.dec_ready_o), 0);
      cycle();
      dec(1, 0, 0, 0, 0, 1); cycle();
      chk("t4_id5", 32'(bus.ren_ckpt_id_o), 0);

      // backpressure hold, then a mispredict kills the held slot
      for (int i = 0; i < 3; i++) begin
         dec(1, 0, 0, 1, 1, 0); bus.ren_ready_i = 0;
         #1 chk("t5_hold_rdy", 32'(bus.dec_ready_o), 0);
         cycle();
         chk("t5_hold_v", 32'(bus.ren_v_o), 1);
         chk("t5_hold_id", 32'(bus.ren_ckpt_id_o), 0);
      end
      dec(1, 0, 0, 1, 1, 0); bus.ren_ready_i = 0; resolve(1, 1);
      cycle();
      chk("t5_kill", 32'(bus.ren_v_o), 0);

      // flush together with a commit of r2
      do_reset();
      dec(1, 0, 0, 2, 1, 0); cycle();
      idle();
      bus.commit_v_i = 1; bus.commit_w_v_i = 1;
      bus.commit_dest_i = AW'(2); bus.commit_freed_i = PW'(2);
      bus.flush_i = 1;
      cycle();
      dec(1, 2, 0, 0, 0, 0); cycle();
      chk("t6_src1", 32'(bus.ren_src1_o), 8);

      // random run
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         rand_inputs();
         cycle();
      end

      // asynchronous reset mid-stream
      dec(1, 1, 2, 3, 1, 0); cycle();
      #3 reset_n_i = 1'b0;
      #1;
      chk("t7_v", 32'(bus.ren_v_o), 0);
      chk("t7_src1", 32'(bus.ren_src1_o), 0);
      chk("t7_src2", 32'(bus.ren_src2_o), 0);
      chk("t7_dest", 32'(bus.ren_dest_o), 0);
      chk("t7_freed", 32'(bus.ren_freed_o), 0);
      chk("t7_ckpt", 32'(bus.ren_ckpt_id_o), 0);
      idle();
      model_reset();
      repeat (2) @(negedge clk_i);
      reset_n_i = 1'b1;
      for (int n = 0; n < 500; n++) begin
         rand_inputs();
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
